// File: rtl/actor_pkg.sv
// Shared constants and types for the actor mover: key codes, door codes
// and the movement FSM state encoding.
package actor_pkg;

  // Keyboard scan codes the mover reacts to
  localparam logic [7:0] KEY_LEFT   = 8'd4;
  localparam logic [7:0] KEY_RIGHT  = 8'd7;
  localparam logic [7:0] KEY_DOWN   = 8'd22;
  localparam logic [7:0] KEY_UP     = 8'd26;
  localparam logic [7:0] KEY_ATTACK = 8'd44;

  // Door taken on the last commit (0 = stayed in the room)
  localparam logic [2:0] DOOR_NONE  = 3'd0;
  localparam logic [2:0] DOOR_EAST  = 3'd1;
  localparam logic [2:0] DOOR_WEST  = 3'd2;
  localparam logic [2:0] DOOR_NORTH = 3'd3;
  localparam logic [2:0] DOOR_SOUTH = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PROBE_A = 3'd1,
    PROBE_B = 3'd2,
    CHECK   = 3'd3,
    COMMIT  = 3'd4
  } state_t;

  // True for the four direction keys that need a collision probe
  function automatic logic is_move_key(input logic [7:0] key);
    return (key == KEY_LEFT) || (key == KEY_RIGHT) ||
           (key == KEY_DOWN) || (key == KEY_UP);
  endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Turns the slow frame_clk level into a one-Clk pulse on its rising edge.
module frame_edge_detect (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic rise
);

  logic frame_d;

  // Remember last cycle's frame_clk level
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) frame_d <= 1'b0;
    else          frame_d <= frame_clk;
  end

  assign rise = frame_clk & ~frame_d;

endmodule

// File: rtl/actor_mover.sv
// Per-frame actor movement: probes two sprite corners in an external
// collision ROM, then commits the move (or a 1-pixel bounce), handles room
// doors and the attack/cooldown timer.
module actor_mover
  import actor_pkg::*;
#(
  parameter int SIZE         = 32,
  parameter int STEP         = 3,
  parameter int START_X      = 336,
  parameter int START_Y      = 400,
  parameter int Y_TOP        = 32,
  parameter int Y_BOT        = 447,
  parameter int X_EDGE       = 607,
  parameter int X_MAX        = 639,
  parameter int ATK_FRAMES   = 8,
  parameter int ATK_COOLDOWN = 16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [2:0] room,
  output logic [9:0] probe_x,
  output logic [9:0] probe_y,
  output logic [2:0] probe_room,
  input  logic       probe_wall,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [2:0] doorcode,
  output logic       attack,
  output logic       busy
);

  localparam logic [9:0] STEP_V   = 10'(STEP);
  localparam logic [9:0] SIZE_V   = 10'(SIZE);
  localparam logic [9:0] START_XV = 10'(START_X);
  localparam logic [9:0] START_YV = 10'(START_Y);
  localparam logic [9:0] Y_TOP_V  = 10'(Y_TOP);
  localparam logic [9:0] Y_BOT_V  = 10'(Y_BOT);
  localparam logic [9:0] X_EDGE_V = 10'(X_EDGE);
  localparam logic [9:0] X_MAX_V  = 10'(X_MAX);

  // The commit that ends the attack is the first cooldown commit, so the
  // cooldown counter is loaded one short of the full cooldown length.
  localparam int ATK_W   = $clog2(ATK_FRAMES + 1);
  localparam int CD_W    = (ATK_COOLDOWN > 1) ? $clog2(ATK_COOLDOWN) : 1;
  localparam int CD_LOAD = (ATK_COOLDOWN > 0) ? ATK_COOLDOWN - 1 : 0;

  state_t           state, state_nxt;
  logic             rise, accept;
  logic [7:0]       key_q;
  logic             wall_a, wall_b;
  logic [9:0]       next_x, next_y;
  logic [2:0]       door_nxt;
  logic [ATK_W-1:0] atk_cnt;
  logic [CD_W-1:0]  cd_cnt;

  frame_edge_detect u_edge (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .rise      (rise)
  );

  // Frame ticks arriving while a move is in flight are dropped
  assign accept = rise && (state == IDLE);
  assign busy   = (state != IDLE);

  // Candidate position for key, then corner A or B of the sprite there
  function automatic logic [19:0] corner(input logic [7:0] key,
                                         input logic [9:0] px,
                                         input logic [9:0] py,
                                         input logic       sel_b);
    logic [9:0] cx, cy, x, y;
    cx = px;
    cy = py;
    case (key)
      KEY_LEFT:  cx = px - STEP_V;
      KEY_RIGHT: cx = px + STEP_V;
      KEY_DOWN:  cy = py + STEP_V;
      KEY_UP:    cy = py - STEP_V;
      default:   ;
    endcase
    x = cx;
    y = cy;
    case (key)
      KEY_LEFT:  y = sel_b ? cy + SIZE_V : cy;
      KEY_RIGHT: begin
        x = cx + SIZE_V;
        y = sel_b ? cy + SIZE_V : cy;
      end
      KEY_DOWN: begin
        y = cy + SIZE_V;
        x = sel_b ? cx + SIZE_V : cx;
      end
      KEY_UP:    x = sel_b ? cx + SIZE_V : cx;
      default:   ;
    endcase
    return {x, y};
  endfunction

  // FSM state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state: probe sequence for direction keys, straight to commit otherwise
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_move_key(keycode) ? PROBE_A : COMMIT;
      PROBE_A: state_nxt = PROBE_B;
      PROBE_B: state_nxt = CHECK;
      CHECK:   state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the frame's key/room, drive probe addresses, collect wall results
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_q      <= 8'd0;
      probe_room <= 3'd0;
      probe_x    <= 10'd0;
      probe_y    <= 10'd0;
      wall_a     <= 1'b0;
      wall_b     <= 1'b0;
    end else if (accept) begin
      key_q      <= keycode;
      probe_room <= room;
      wall_a     <= 1'b0;
      wall_b     <= 1'b0;
      if (is_move_key(keycode)) {probe_x, probe_y} <= corner(keycode, pos_x, pos_y, 1'b0);
    end else begin
      case (state)
        PROBE_A: {probe_x, probe_y} <= corner(key_q, pos_x, pos_y, 1'b1);
        PROBE_B: wall_a <= probe_wall;
        CHECK:   wall_b <= probe_wall;
        default: ;
      endcase
    end
  end

  // Commit target: move or bounce, then door override from the pre-move position
  always_comb begin
    next_x   = pos_x;
    next_y   = pos_y;
    door_nxt = DOOR_NONE;
    case (key_q)
      KEY_LEFT:  next_x = (wall_a | wall_b) ? pos_x + 10'd1 : pos_x - STEP_V;
      KEY_RIGHT: next_x = (wall_a | wall_b) ? pos_x - 10'd1 : pos_x + STEP_V;
      KEY_DOWN:  next_y = (wall_a | wall_b) ? pos_y - 10'd1 : pos_y + STEP_V;
      KEY_UP:    next_y = (wall_a | wall_b) ? pos_y + 10'd1 : pos_y - STEP_V;
      default:   ;
    endcase
    if (pos_y < Y_TOP_V) begin
      next_y   = Y_BOT_V;
      door_nxt = DOOR_NORTH;
    end else if (pos_y > Y_BOT_V) begin
      next_y   = Y_TOP_V;
      door_nxt = DOOR_SOUTH;
    end else if ((pos_x == 10'd0) || (pos_x > X_MAX_V)) begin
      next_x   = X_EDGE_V;
      door_nxt = DOOR_WEST;
    end else if (pos_x > X_EDGE_V) begin
      next_x   = 10'd1;
      door_nxt = DOOR_EAST;
    end
  end

  // Position, door and attack/cooldown timer update once per commit
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_x    <= START_XV;
      pos_y    <= START_YV;
      doorcode <= DOOR_NONE;
      attack   <= 1'b0;
      atk_cnt  <= '0;
      cd_cnt   <= '0;
    end else if (state == COMMIT) begin
      pos_x    <= next_x;
      pos_y    <= next_y;
      doorcode <= door_nxt;
      if (attack) begin
        if (atk_cnt <= ATK_W'(1)) begin
          attack <= 1'b0;
          cd_cnt <= CD_W'(CD_LOAD);
        end else begin
          atk_cnt <= atk_cnt - ATK_W'(1);
        end
      end else if (cd_cnt != '0) begin
        cd_cnt <= cd_cnt - CD_W'(1);
      end else if (key_q == KEY_ATTACK) begin
        attack  <= 1'b1;
        atk_cnt <= ATK_W'(ATK_FRAMES);
      end
    end
  end

endmodule

// File: tb/tb_actor_mover.sv
// Self-checking bench for actor_mover: directed scenarios plus randomized
// frames, all compared against a frame-level reference model.
module tb_actor_mover;

  localparam int SIZE = 32, STEP = 3, START_X = 336, START_Y = 400;
  localparam int Y_TOP = 32, Y_BOT = 447, X_EDGE = 607, X_MAX = 639;
  localparam int ATK_FRAMES = 8, ATK_COOLDOWN = 16;

  logic       Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
  logic [7:0] keycode = 8'd0;
  logic [2:0] room = 3'd0;
  logic       probe_wall = 1'b0;
  logic [9:0] probe_x, probe_y, pos_x, pos_y;
  logic [2:0] probe_room, doorcode;
  logic       attack, busy;

  int checks = 0, errors = 0;
  int wall_mode = 0, wall_x = 0, wall_y = 0;
  int mx, my, mdoor, mphase;
  int ax, ay, bx, by;
  int busy_cycles, obs_room, idle_busy;
  int obs_px[8], obs_py[8];

  always #5 Clk = ~Clk;

  actor_mover dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .keycode    (keycode),
    .room       (room),
    .probe_x    (probe_x),
    .probe_y    (probe_y),
    .probe_room (probe_room),
    .probe_wall (probe_wall),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .doorcode   (doorcode),
    .attack     (attack),
    .busy       (busy)
  );

  // Collision map: 0 none, 1 everywhere, 2 single pixel, 3 pseudo-random tiles
  function automatic bit wall_fn(int x, int y, int r);
    case (wall_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (x == wall_x) && (y == wall_y);
      default: return ((((x >> 3) * 31) + ((y >> 3) * 17) + r * 7) % 5) == 0;
    endcase
  endfunction

  // External collision ROM with one Clk of read latency
  always @(posedge Clk) probe_wall <= wall_fn(probe_x, probe_y, probe_room);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap(int v);
    return ((v % 1024) + 1024) % 1024;
  endfunction

  function automatic bit is_move(int key);
    return (key == 4) || (key == 7) || (key == 22) || (key == 26);
  endfunction

  function automatic int model_attack();
    return (mphase >= 0 && mphase < ATK_FRAMES) ? 1 : 0;
  endfunction

  task automatic model_reset();
    mx = START_X; my = START_Y; mdoor = 0; mphase = -1;
  endtask

  // One frame of game behaviour, from the rules rather than the FSM
  task automatic model_frame(input int key, input int r);
    int dx, dy, cx, cy, nx, ny, d;
    bit blocked;
    dx = 0; dy = 0;
    case (key)
      4: dx = -1;  7: dx = 1;  22: dy = 1;  26: dy = -1;
      default: ;
    endcase
    cx = wrap(mx + dx * STEP);
    cy = wrap(my + dy * STEP);
    case (key)
      4:  begin ax = cx;               ay = cy;               bx = cx;               by = wrap(cy + SIZE); end
      7:  begin ax = wrap(cx + SIZE);  ay = cy;               bx = wrap(cx + SIZE);  by = wrap(cy + SIZE); end
      22: begin ax = cx;               ay = wrap(cy + SIZE);  bx = wrap(cx + SIZE);  by = wrap(cy + SIZE); end
      default: begin ax = cx;          ay = cy;               bx = wrap(cx + SIZE);  by = cy;               end
    endcase
    nx = mx; ny = my;
    if (is_move(key)) begin
      blocked = wall_fn(ax, ay, r) || wall_fn(bx, by, r);
      nx = blocked ? wrap(mx - dx) : cx;
      ny = blocked ? wrap(my - dy) : cy;
    end
    d = 0;
    if (my < Y_TOP)                    begin ny = Y_BOT;  d = 3; end
    else if (my > Y_BOT)               begin ny = Y_TOP;  d = 4; end
    else if (mx == 0 || mx > X_MAX)    begin nx = X_EDGE; d = 2; end
    else if (mx > X_EDGE)              begin nx = 1;      d = 1; end
    if (mphase >= 0) begin
      mphase++;
      if (mphase == ATK_FRAMES + ATK_COOLDOWN) mphase = -1;
    end
    if (mphase < 0 && key == 44) mphase = 0;
    mx = nx; my = ny; mdoor = d;
  endtask

  // Drive one frame tick and compare the outcome with the model
  task automatic run_frame(input int key, input int r, input bit glitch);
    model_frame(key, r);
    for (int i = 0; i < 8; i++) begin obs_px[i] = -1; obs_py[i] = -1; end
    @(negedge Clk);
    keycode = 8'(key); room = 3'(r); frame_clk = 1'b1;
    busy_cycles = 0; obs_room = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (!busy) break;
      obs_px[i] = probe_x; obs_py[i] = probe_y;
      if (i == 0) obs_room = probe_room;
      if (glitch && i == 0) frame_clk = 1'b0;
      if (glitch && i == 1) frame_clk = 1'b1;
      busy_cycles++;
    end
    frame_clk = 1'b0;
    check("busy_len", busy_cycles, is_move(key) ? 4 : 1);
    check("probe_room", obs_room, r);
    if (is_move(key)) begin
      check("probe_ax", obs_px[0], ax);
      check("probe_ay", obs_py[0], ay);
      check("probe_bx", obs_px[1], bx);
      check("probe_by", obs_py[1], by);
    end
    check("pos_x", pos_x, mx);
    check("pos_y", pos_y, my);
    check("doorcode", doorcode, mdoor);
    check("attack", attack, model_attack());
  endtask

  initial begin
    int k, r;
    model_reset();
    repeat (3) @(negedge Clk);
    check("rst_pos_x", pos_x, START_X);
    check("rst_pos_y", pos_y, START_Y);
    check("rst_door", doorcode, 0);
    check("rst_attack", attack, 0);
    check("rst_busy", busy, 0);
    check("rst_probe_x", probe_x, 0);
    check("rst_probe_y", probe_y, 0);
    Reset_n = 1'b1;

    // Right move, no walls
    run_frame(7, 0, 1'b0);
    check("r028_x", pos_x, 339);
    check("r028_y", pos_y, 400);
    check("r028_busy", busy_cycles, 4);
    run_frame(4, 0, 1'b0);
    check("back_x", pos_x, 336);

    // Left move blocked at corner B only: bounce right by one
    wall_mode = 2; wall_x = 333; wall_y = 432;
    run_frame(4, 1, 1'b0);
    check("r029_x", pos_x, 337);
    check("r029_ax", obs_px[0], 333);
    check("r029_ay", obs_py[0], 400);
    check("r029_bx", obs_px[1], 333);
    check("r029_by", obs_py[1], 432);

    // Walk left down to x=1, wrap past zero, then take the west door
    wall_mode = 0;
    repeat (112) run_frame(4, 0, 1'b0);
    check("r031_x1", pos_x, 1);
    run_frame(4, 0, 1'b0);
    check("r031_wrap", pos_x, 1022);
    run_frame(4, 0, 1'b0);
    check("r031_door_x", pos_x, 607);
    check("r031_door", doorcode, 2);

    // Two upward bounces then walk up to y=30 and take the north door
    wall_mode = 1;
    run_frame(26, 0, 1'b0);
    run_frame(26, 0, 1'b0);
    check("bounce_y", pos_y, 402);
    wall_mode = 0;
    repeat (124) run_frame(26, 0, 1'b0);
    check("r030_y30", pos_y, 30);
    run_frame(0, 0, 1'b0);
    check("r030_y", pos_y, 447);
    check("r030_door", doorcode, 3);
    run_frame(0, 0, 1'b0);
    check("r030_door_clr", doorcode, 0);

    // Attack key held: 8 frames on, 16 cooldown, then on again
    for (int n = 1; n <= 30; n++) begin
      run_frame(44, 0, 1'b0);
      check("r032_attack", attack, (n <= 8 || n >= 25) ? 1 : 0);
    end

    // A frame tick landing mid-probe must be ignored
    run_frame(7, 0, 1'b1);
    idle_busy = 0;
    repeat (4) begin
      @(negedge Clk);
      if (busy) idle_busy++;
    end
    check("busy_glitch", idle_busy, 0);

    // Randomized frames on a tiled wall map
    wall_mode = 3;
    repeat (200) begin
      k = $urandom_range(0, 9);
      r = $urandom_range(0, 7);
      case (k)
        0, 1: k = 4;
        2, 3: k = 7;
        4, 5: k = 22;
        6, 7: k = 26;
        8:    k = 44;
        default: k = $urandom_range(0, 255);
      endcase
      run_frame(k, r, 1'b0);
    end

    // Reset asserted during PROBE_B acts immediately
    wall_mode = 0;
    @(negedge Clk);
    keycode = 8'd7; room = 3'd2; frame_clk = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    check("r033_busy_pre", busy, 1);
    Reset_n = 1'b0;
    #1;
    check("r033_x", pos_x, START_X);
    check("r033_y", pos_y, START_Y);
    check("r033_busy", busy, 0);
    check("r033_probe_x", probe_x, 0);
    check("r033_probe_y", probe_y, 0);
    check("r033_door", doorcode, 0);
    check("r033_attack", attack, 0);
    frame_clk = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    run_frame(7, 0, 1'b0);
    check("r024_x", pos_x, 339);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/actor_mover.md
ACTOR_MOVER -- requirements
Module: actor_mover

Interface
REQ-001 SHALL have parameters (name, default, meaning): SIZE, 32, sprite edge in pixels.
REQ-002 SHALL have parameter STEP, 3, pixels moved per frame.
REQ-003 SHALL have parameters START_X/START_Y, 336/400, reset position.
REQ-004 SHALL have parameters Y_TOP, 32; Y_BOT, 447; X_EDGE, 607; X_MAX, 639 (door thresholds).
REQ-005 SHALL have parameters ATK_FRAMES, 8, attack duration; ATK_COOLDOWN, 16, frames before re-attack.
REQ-006 SHALL have ports: Clk  in  1  system clock; Reset_n  in  1  async active-low reset.
REQ-007 SHALL have ports: frame_clk  in  1  frame tick; keycode  in  8  current key; room  in  3  room index, passed to probe port.
REQ-008 SHALL have ports: probe_x, probe_y  out  10  collision-ROM address; probe_room  out  3; probe_wall  in  1  ROM result, valid 1 Clk after address.
REQ-009 SHALL have ports: pos_x, pos_y  out  10  actor position; doorcode  out  3  door taken; attack  out  1; busy  out  1  FSM not IDLE.

Function
REQ-010 Clock and reset: one clock, Clk; reset is asynchronous and active-low, Reset_n.
REQ-011 SHALL detect frame_clk rising edge (registered delay, high-now & low-before); edge while busy=1 is ignored.
REQ-012 FSM states IDLE, PROBE_A, PROBE_B, CHECK, COMMIT; IDLE->PROBE_A on edge with move key (4 left, 7 right, 22 down, 26 up), IDLE->COMMIT on edge otherwise.
REQ-013 Candidate = pos +/- STEP on the key's axis, mod 1024 (10-bit wrap).
REQ-014 Corners probed: left cand(x,y),(x,y+SIZE); right (x+SIZE,y),(x+SIZE,y+SIZE); down (x,y+SIZE),(x+SIZE,y+SIZE); up (x,y),(x+SIZE,y).
REQ-015 PROBE_A drives corner A; PROBE_B samples wall A and drives corner B; CHECK samples wall B; all ->next state unconditionally.
REQ-016 COMMIT: if either wall sample 1, move 1 pixel opposite to key direction; else move to candidate; ->IDLE.
REQ-017 Position update occurs at COMMIT clock edge: 4 Clk after edge detect for move keys, 1 Clk otherwise.
REQ-018 Door check at COMMIT uses pre-move pos, priority: y<Y_TOP -> y=Y_BOT, door 3; y>Y_BOT -> y=Y_TOP, door 4; x==0 or x>X_MAX -> x=X_EDGE, door 2; X_EDGE<x<=X_MAX -> x=1, door 1; door overrides move on that axis.
REQ-019 doorcode registered at COMMIT, 0 if no door, held until next COMMIT.
REQ-020 Key 44 at COMMIT with cooldown 0 and attack 0 SHALL assert attack for ATK_FRAMES commits, then count ATK_COOLDOWN commits; presses meanwhile ignored; no movement on key 44.
REQ-021 Unknown keycodes: no move, no attack; counters still advance.
REQ-022 probe_room = room registered at edge detect, stable through the probe sequence.

Reset
REQ-023 Reset_n low SHALL asynchronously set pos=START, doorcode=0, attack=0, counters=0, probe_x/y=0, state IDLE, busy=0, even mid-probe.
REQ-024 First edge after Reset_n release SHALL be processed normally.

Structure
REQ-025 Package actor_pkg SHALL hold key constants (4,7,22,26,44), door code constants, and the FSM state enum.
REQ-026 One sub-module natural: frame_edge_detect (delay flop + rising-edge pulse).
REQ-027 Collision ROM is external; no ROM instantiated inside.

Verification
REQ-028 Reset, key 7, wall=0, one edge -> pos (339,400), busy high 4 Clk, doorcode 0.
REQ-029 Key 4, wall=1 at corner B only -> pos (337,400); probe_x/y show (333,400) then (333,432).
REQ-030 pos_y=30, key 0, edge -> pos_y=447, doorcode 3; next edge doorcode 0.
REQ-031 pos_x=1, key 4, no wall -> x wraps to 1022, next edge -> x=607, doorcode 2.
REQ-032 Key 44 held 30 edges -> attack high edges 1-8, low 9-24, high again from edge 25.
REQ-033 Reset_n low during PROBE_B -> immediate START pos, IDLE; edge in busy window ignored.
